// File: rtl/two_way_cache_ctrl_if.sv
// Bus bundle for the 2-way cache controller: CPU request side, memory beat side
// and the LRU unit hookup. The cache controller is the slave; its environment is the master.
interface two_way_cache_ctrl_if #(
  parameter int ADDR_SIZE = 32
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_SIZE-1:0] cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [31:0]          cpu_rdata;
  logic                 cpu_ready;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;
  logic                 mem_ack;
  logic [ADDR_SIZE-1:0] lru_addr;
  logic                 lru_preferred;
  logic                 lru_replace;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack, lru_preferred,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, lru_addr, lru_replace
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack, lru_preferred,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, lru_addr, lru_replace
  );
endinterface

// File: rtl/two_way_cache_ctrl.sv
// Write-through, no-write-allocate 2-way set-associative data cache controller
// with word-by-word block refill; victim way comes from an external LRU unit.
module two_way_cache_ctrl #(
  parameter int ADDR_SIZE       = 32,
  parameter int NUM_SETS        = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input logic                  clk,
  input logic                  rst,
  two_way_cache_ctrl_if.slave  bus
);
  localparam int WB    = $clog2(WORDS_PER_BLOCK);
  localparam int SB    = $clog2(NUM_SETS);
  localparam int TB    = ADDR_SIZE - 2 - WB - SB;
  localparam int IB    = SB + WB;
  localparam int DEPTH = NUM_SETS * WORDS_PER_BLOCK;
  localparam logic [WB-1:0] LAST_WORD = WB'(WORDS_PER_BLOCK - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    FILL    = 3'd2,
    RESPOND = 3'd3,
    WRITE   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 victim_q, victim_d;
  logic [WB-1:0]        cnt_q, cnt_d;
  logic [1:0][NUM_SETS-1:0] valid_q;

  logic [TB-1:0] tag_q  [2][NUM_SETS];
  logic [31:0]   data_q [2][DEPTH];

  logic [WB-1:0] word_s;
  logic [SB-1:0] set_s;
  logic [TB-1:0] tag_s;
  logic          hit0_s, hit1_s, hit_s;
  logic [31:0]   hit_word_s, victim_word_s;

  logic          dwe_s, dway_s, twe_s;
  logic [IB-1:0] didx_s;
  logic [31:0]   dwdata_s;

  logic                 cpu_ready_s, mem_req_s, mem_we_s, lru_replace_s;
  logic [31:0]          cpu_rdata_s, mem_wdata_s;
  logic [ADDR_SIZE-1:0] mem_addr_s;

  assign word_s = addr_q[2 +: WB];
  assign set_s  = addr_q[2 + WB +: SB];
  assign tag_s  = addr_q[ADDR_SIZE-1 -: TB];

  assign hit0_s        = valid_q[0][set_s] && (tag_q[0][set_s] == tag_s);
  assign hit1_s        = valid_q[1][set_s] && (tag_q[1][set_s] == tag_s);
  assign hit_s         = hit0_s || hit1_s;
  assign hit_word_s    = data_q[hit1_s][{set_s, word_s}];
  assign victim_word_s = data_q[victim_q][{set_s, word_s}];

  // Next-state, request latching, array write controls and bus outputs
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    victim_d      = victim_q;
    cnt_d         = cnt_q;
    cpu_ready_s   = 1'b0;
    cpu_rdata_s   = 32'd0;
    mem_req_s     = 1'b0;
    mem_we_s      = 1'b0;
    mem_addr_s    = '0;
    mem_wdata_s   = 32'd0;
    lru_replace_s = 1'b0;
    dwe_s         = 1'b0;
    dway_s        = 1'b0;
    didx_s        = {set_s, word_s};
    dwdata_s      = wdata_q;
    twe_s         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          we_d    = bus.cpu_we;
          wdata_d = bus.cpu_wdata;
          state_d = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (we_q) begin
          // Store hit updates the cached copy; memory is always written through
          if (hit_s) begin
            dwe_s  = 1'b1;
            dway_s = hit1_s;
          end else begin
            dwe_s  = 1'b0;
          end
          state_d = WRITE;
        end else if (hit_s) begin
          cpu_ready_s = 1'b1;
          cpu_rdata_s = hit_word_s;
          state_d     = IDLE;
        end else begin
          victim_d = bus.lru_preferred;
          cnt_d    = '0;
          state_d  = FILL;
        end
      end
      FILL: begin
        mem_req_s  = 1'b1;
        mem_addr_s = {addr_q[ADDR_SIZE-1:2+WB], cnt_q, 2'b00};
        if (bus.mem_ack) begin
          dwe_s    = 1'b1;
          dway_s   = victim_q;
          didx_s   = {set_s, cnt_q};
          dwdata_s = bus.mem_rdata;
          cnt_d    = cnt_q + WB'(1);
          if (cnt_q == LAST_WORD) begin
            twe_s         = 1'b1;
            lru_replace_s = 1'b1;
            state_d       = RESPOND;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      RESPOND: begin
        cpu_ready_s = 1'b1;
        cpu_rdata_s = victim_word_s;
        state_d     = IDLE;
      end
      WRITE: begin
        mem_req_s   = 1'b1;
        mem_we_s    = 1'b1;
        mem_addr_s  = {addr_q[ADDR_SIZE-1:2], 2'b00};
        mem_wdata_s = wdata_q;
        if (bus.mem_ack) begin
          cpu_ready_s = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state, latched request and valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= 32'd0;
      victim_q <= 1'b0;
      cnt_q    <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      victim_q <= victim_d;
      cnt_q    <= cnt_d;
      if (twe_s) begin
        valid_q[victim_q][set_s] <= 1'b1;
      end
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (dwe_s) begin
      data_q[dway_s][didx_s] <= dwdata_s;
    end
    if (twe_s) begin
      tag_q[victim_q][set_s] <= tag_s;
    end
  end

  // Completion and replace strobes are suppressed while reset is held
  assign bus.cpu_ready   = cpu_ready_s & ~rst;
  assign bus.lru_replace = lru_replace_s & ~rst;
  assign bus.cpu_rdata   = cpu_rdata_s;
  assign bus.mem_req     = mem_req_s;
  assign bus.mem_we      = mem_we_s;
  assign bus.mem_addr    = mem_addr_s;
  assign bus.mem_wdata   = mem_wdata_s;
  assign bus.lru_addr    = addr_q;
endmodule

// File: doc/two_way_cache_ctrl.md
Name: two_way_cache_ctrl

Overview:
- Control and storage stage of the 2-way set-associative data cache.
- Sits directly upstream of the two-way LRU replacement unit: drives its address and replace strobe, and consumes its preferred-way output as the victim select.
- Serves single-word CPU loads/stores; refills blocks word-by-word from main memory.
- Write-through, no-write-allocate.

Parameters:
- ADDR_SIZE, 32, byte address width.
- NUM_SETS, 16, sets per way (power of 2).
- WORDS_PER_BLOCK, 8, 32-bit words per block (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- cpu_req  in  1  request valid; held with addr/we/wdata until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_SIZE  byte address, word aligned.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data, valid when cpu_ready.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_req  out  1  memory beat request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_SIZE  word-aligned memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid with mem_ack.
- mem_ack  in  1  beat complete.
- lru_addr  out  ADDR_SIZE  address presented to the LRU unit (latched request address).
- lru_preferred  in  1  way to replace for the lru_addr set.
- lru_replace  out  1  one-cycle pulse: the refill into lru_preferred completed.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Outputs on reset: state IDLE; all valid bits cleared; cpu_ready, mem_req, mem_we and lru_replace = 0; cpu_rdata, mem_addr and mem_wdata = 0.
  - Tag/data arrays are not reset.
- Address split, LSB first: byte[1:0], word[log2(WPB)], set[log2(NUM_SETS)], tag = remainder.
- IDLE:
  - On cpu_req, latch addr/we/wdata, go to CHECK.
  - No new request is accepted in any other state.
- CHECK: compare tags in both ways; hit = valid & tag match. Both ways matching is impossible by construction.
  - Load hit: cpu_ready=1 and cpu_rdata = hit word this cycle -> IDLE. Latency is 1 cycle after acceptance. No LRU update on hit.
  - Load miss: victim = lru_preferred, sampled this cycle and held; word counter = 0 -> FILL.
  - Store hit: write wdata into the hit way's word this cycle -> WRITE.
  - Store miss: no array change -> WRITE.
- FILL:
  - mem_req=1, mem_we=0, mem_addr = {tag, set, counter, 2'b00}.
  - Address stays stable until mem_ack, then advances next cycle; mem_req stays high between beats.
  - On each mem_ack: write mem_rdata into victim way[set][counter], counter++.
  - On the ack of the last beat (counter = WPB-1): write tag, set valid, pulse lru_replace -> RESPOND.
  - mem_ack while mem_req=0 is ignored.
- RESPOND: mem_req=0; cpu_ready=1, cpu_rdata = requested word from victim way -> IDLE.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr/mem_wdata from the latched request.
  - On mem_ack: cpu_ready=1 that same cycle -> IDLE.
- cpu_ready is never asserted for more than one cycle per request.
- lru_replace pulses exactly once per completed refill and never on hits or stores.
- Reset mid-FILL or mid-WRITE:
  - Abandon the transaction; mem_req=0 the next cycle.
  - A partially filled way stays invalid (all valid cleared). No cpu_ready, no lru_replace.

Test Plan:
- Cold load 0x0000_0104 with memory returning 0xA0+k for beat k (ack 2 cycles after each req) -> 8 beats at mem_addr 0x100..0x11C; lru_replace pulses once; cpu_ready with rdata 0xA1.
- Repeat load 0x0000_0104 -> cpu_ready 1 cycle after acceptance, rdata 0xA1, mem_req stays 0, no lru_replace.
- Load 0x0000_2104 (same set 8, new tag) with lru_preferred=1 -> refill into way 1; then reload 0x104 -> hit from way 0, no memory traffic.
- Store 0xDEADBEEF to 0x108 (hit) -> one memory write beat to 0x108; cpu_ready on mem_ack; a following load of 0x108 hits with rdata 0xDEADBEEF.
- Store to 0x4000 (miss) -> one memory write beat; a following load of 0x4000 misses and refills.
- rst asserted after beat 3 of a refill -> mem_req low next cycle; no cpu_ready, no lru_replace; a reload of the same address performs a full 8-beat refill.
